// File: rtl/touch_adc_spi_ctrl_if.sv
// Touch ADC serial bus: pen request in, chip select/clock/data and frame
// status out toward the ADC and the DOUT receiver.
interface touch_adc_spi_ctrl_if;
  logic       iPENIRQ_n;
  logic       oADC_CS_n;
  logic       oADC_DCLK;
  logic       oADC_DIN;
  logic       oTRANS_EN;
  logic [6:0] oCOUNT_80;
  logic       oDONE;

  modport master (
    input  iPENIRQ_n,
    output oADC_CS_n,
    output oADC_DCLK,
    output oADC_DIN,
    output oTRANS_EN,
    output oCOUNT_80,
    output oDONE
  );

  modport slave (
    output iPENIRQ_n,
    input  oADC_CS_n,
    input  oADC_DCLK,
    input  oADC_DIN,
    input  oTRANS_EN,
    input  oCOUNT_80,
    input  oDONE
  );
endinterface

// File: rtl/touch_adc_spi_ctrl.sv
// Touch-panel ADC serial master: one 80 half-period frame per pen-down
// period, X command then overlapped Y command, repeated at a fixed gap.
module touch_adc_spi_ctrl #(
  parameter int         DIV_HALF   = 25,
  parameter int         GAP_CYCLES = 50000,
  parameter logic [7:0] CMD_X      = 8'h90,
  parameter logic [7:0] CMD_Y      = 8'hD0
) (
  input logic iCLK,
  input logic iRST,
  touch_adc_spi_ctrl_if.master bus
);

  localparam int DW = $clog2(DIV_HALF);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            pen_m, pen_s;
  logic            cs_n_q, dclk_q, din_q;
  logic            te_q, done_q;
  logic            done_d, din_d;
  logic [2:0]      bit_i;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pen_m <= 1'b1;
      pen_s <= 1'b1;
    end else begin
      pen_m <= bus.iPENIRQ_n;
      pen_s <= pen_m;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!pen_s) begin
          state_d = SETUP;
          div_d   = '0;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = XFER;
          div_d   = '0;
          cnt_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      XFER: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (cnt_q == 7'd79) begin
            state_d = GAP;
            cnt_d   = '0;
            gap_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        // pen is re-examined only once the gap has fully elapsed
        if (gap_q == GAP_LAST) begin
          state_d = pen_s ? IDLE : SETUP;
          div_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // each command bit spans one full DCLK period (even+odd count)
  always_comb begin
    bit_i = 3'd7 - cnt_d[3:1];
    din_d = 1'b0;
    if (state_d == XFER) begin
      unique case (1'b1)
        (cnt_d < 7'd16):
          din_d = CMD_X[bit_i];
        (cnt_d >= 7'd32 && cnt_d < 7'd48):
          din_d = CMD_Y[bit_i];
        default:
          din_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      dclk_q  <= 1'b0;
      din_q   <= 1'b0;
      te_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= !(state_d == SETUP ||
                   state_d == XFER);
      dclk_q  <= (state_d == XFER) && cnt_d[0];
      din_q   <= din_d;
      te_q    <= (state_d == XFER);
      done_q  <= done_d;
    end
  end

  assign bus.oADC_CS_n = cs_n_q;
  assign bus.oADC_DCLK = dclk_q;
  assign bus.oADC_DIN  = din_q;
  assign bus.oTRANS_EN = te_q;
  assign bus.oCOUNT_80 = cnt_q;
  assign bus.oDONE     = done_q;

endmodule

// File: tb/tb_touch_adc_spi_ctrl.sv
// Bench for touch_adc_spi_ctrl: ADC model, DOUT receiver model and a
// per-frame scoreboard checked on each DONE pulse.
module tb_touch_adc_spi_ctrl;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  touch_adc_spi_ctrl_if bus ();

  touch_adc_spi_ctrl #(
    .DIV_HALF  (2),
    .GAP_CYCLES(10),
    .CMD_X     (8'h90),
    .CMD_Y     (8'hD0)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmdx;
    logic [7:0]  cmdy;
    int          edges;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  exp_t sbq[$];

  // ADC model: latch command on DCLK rise, shift result on DCLK fall
  int          r    = 0;
  logic [7:0]  acmd = 8'h00;
  logic [11:0] xv   = 12'h000;
  logic [11:0] yv   = 12'h000;
  logic        adc_dout = 1'b0;

  function automatic logic [11:0] conv(input logic [7:0] c);
    case (c[6:4])
      3'b001:  return 12'hA5C;
      3'b101:  return 12'h3F1;
      default: return 12'h000;
    endcase
  endfunction

  always @(posedge bus.oADC_DCLK or posedge bus.oADC_CS_n) begin
    if (bus.oADC_CS_n) begin
      r <= 0;
    end else begin
      r    <= r + 1;
      acmd <= {acmd[6:0], bus.oADC_DIN};
      if (r + 1 == 8)
        xv <= conv({acmd[6:0], bus.oADC_DIN});
      if (r + 1 == 24)
        yv <= conv({acmd[6:0], bus.oADC_DIN});
    end
  end

  always @(negedge bus.oADC_DCLK or posedge bus.oADC_CS_n) begin
    if (bus.oADC_CS_n)
      adc_dout <= 1'b0;
    else if (r >= 9 && r <= 20)
      adc_dout <= xv[20 - r];
    else if (r >= 25 && r <= 36)
      adc_dout <= yv[36 - r];
    else
      adc_dout <= 1'b0;
  end

  // monitor: receiver + frame observer, scoreboard pop on DONE
  logic        prev_te   = 1'b0;
  logic        prev_dclk = 1'b0;
  int          edges     = 0;
  int          hold      = 0;
  logic [6:0]  pcnt      = 7'd0;
  logic [7:0]  mx = 8'h00, my = 8'h00;
  logic [11:0] rx = 12'h000, ry = 12'h000;
  logic        walk_ok = 1'b0;
  logic        din_ok  = 1'b0;

  always @(negedge iCLK) begin
    logic [6:0] c;
    exp_t e;
    c = bus.oCOUNT_80;
    if (iRST) begin
      prev_te   = 1'b0;
      prev_dclk = 1'b0;
    end else begin
      if (bus.oTRANS_EN) begin
        if (!prev_te) begin
          edges = 0; hold = 0;
          mx = 0; my = 0; rx = 0; ry = 0;
          walk_ok = (c == 7'd0);
          din_ok  = 1'b1;
          pcnt    = c;
        end
        if (c == pcnt) begin
          hold++;
        end else begin
          if (hold != 2 || c != pcnt + 7'd1)
            walk_ok = 1'b0;
          hold = 1;
        end
        pcnt = c;
        if (bus.oADC_DCLK && !prev_dclk) begin
          edges++;
          if (edges <= 8)
            mx = {mx[6:0], bus.oADC_DIN};
          else if (edges >= 17 && edges <= 24)
            my = {my[6:0], bus.oADC_DIN};
          if (c[0] && c >= 7'd19 && c <= 7'd41)
            rx = {rx[10:0], adc_dout};
          if (c[0] && c >= 7'd51 && c <= 7'd73)
            ry = {ry[10:0], adc_dout};
        end
        if (bus.oADC_DCLK != c[0])
          din_ok = 1'b0;
        if (!(c < 7'd16 || (c >= 7'd32 && c < 7'd48))
            && bus.oADC_DIN)
          din_ok = 1'b0;
      end
      if (bus.oDONE) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE at cycle %0d required none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("dclk_edges", edges, e.edges);
          chk("cmd_x", mx, e.cmdx);
          chk("cmd_y", my, e.cmdy);
          chk("count_walk",
              walk_ok && pcnt == 7'd79 && hold == 2, 1);
          chk("din_dclk_shape", din_ok, 1);
          chk("x_coord", rx, e.x);
          chk("y_coord", ry, e.y);
          chk("done_outputs",
              {bus.oADC_CS_n, bus.oTRANS_EN, bus.oCOUNT_80},
              {1'b1, 1'b0, 7'd0});
        end
      end
      prev_te   = bus.oTRANS_EN;
      prev_dclk = bus.oADC_DCLK;
    end
  end

  function automatic bit hit(input int sel);
    case (sel)
      0:       return !bus.oADC_CS_n;
      1:       return bus.oTRANS_EN;
      2:       return bus.oDONE;
      default: return bus.oTRANS_EN && bus.oCOUNT_80 == 7'd40;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge iCLK);
      if (hit(sel)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%0d: got no event in %0d cycles required one", sel, lim);
    end
  endtask

  initial begin
    exp_t fr;
    int   t, a, d1;
    logic bad;
    fr = '{8'h90, 8'hD0, 40, 12'hA5C, 12'h3F1};
    bus.iPENIRQ_n = 1'b1;
    iRST = 1'b1;

    repeat (6) begin
      @(posedge iCLK);
      #1 bus.iPENIRQ_n = ~bus.iPENIRQ_n;
    end
    bus.iPENIRQ_n = 1'b1;
    @(negedge iCLK);
    chk("reset_outputs",
        {bus.oADC_CS_n, bus.oADC_DCLK, bus.oADC_DIN,
         bus.oTRANS_EN, bus.oCOUNT_80, bus.oDONE},
        {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0});
    @(posedge iCLK);
    #1 iRST = 1'b0;

    bad = 1'b0;
    repeat (40) begin
      @(negedge iCLK);
      if (!bus.oADC_CS_n || bus.oTRANS_EN || bus.oDONE)
        bad = 1'b1;
    end
    chk("idle_no_pen", bad, 0);

    sbq.push_back(fr);
    @(posedge iCLK);
    #1 bus.iPENIRQ_n = 1'b0;
    t = cyc;
    wait_for(0, 20, a);
    chk("cs_fall_delay", a - t, 3);
    wait_for(1, 20, a);
    chk("trans_en_delay", a - t, 5);
    wait_for(2, 300, a);
    chk("done_delay", a - t, 165);
    d1 = a;

    sbq.push_back(fr);
    wait_for(1, 100, a);
    chk("frame_spacing", a - d1, 13);
    wait_for(3, 300, a);
    bus.iPENIRQ_n = 1'b1;
    wait_for(2, 300, a);
    bad = 1'b0;
    repeat (60) begin
      @(negedge iCLK);
      if (!bus.oADC_CS_n || bus.oTRANS_EN)
        bad = 1'b1;
    end
    chk("idle_after_release", bad, 0);

    bus.iPENIRQ_n = 1'b0;
    wait_for(3, 200, a);
    #2 iRST = 1'b1;
    #1;
    chk("reset_abort",
        {bus.oADC_CS_n, bus.oADC_DCLK, bus.oADC_DIN,
         bus.oTRANS_EN, bus.oCOUNT_80, bus.oDONE},
        {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0});
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    sbq.push_back(fr);
    wait_for(1, 50, a);
    chk("restart_count", bus.oCOUNT_80, 0);
    wait_for(2, 300, a);
    bus.iPENIRQ_n = 1'b1;
    repeat (30) @(negedge iCLK);
    chk("queue_drained", sbq.size(), 0);
    chk("final_idle",
        {bus.oADC_CS_n, bus.oTRANS_EN}, {1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
